string_match_scan: RTL and testbench

Parametrised successor of the per-string parallel matcher. It holds a table of up to NPAT patterns. It accepts a text string over a valid/ready byte stream into an internal buffer, then scans the buffer. The scan tests LANES candidate start offsets of one pattern per cycle, using LANES×PATLEN internal comparators; no external router/ALU is needed. Each pattern gets a tri-state result (found / not found / not evaluated), and done pulses at the end. It sits between the string source (RAM reader) and the result collector.

---
 rtl/string_match_pkg.sv | 20 ++
 rtl/string_match_scan_cmp.sv | 22 ++
 rtl/string_match_scan.sv | 193 +++++++++++++++++++
 tb/tb_string_match_scan.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/string_match_pkg.sv
// Shared result encoding, FSM state type and width helper for the string matcher.
package string_match_pkg;

    localparam logic [1:0] RES_NONE = 2'd2;
    localparam logic [1:0] RES_HIT  = 2'd1;
    localparam logic [1:0] RES_MISS = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_STR,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/string_match_scan_cmp.sv
// One candidate window against one pattern; chars at or beyond len are masked.
// Purely combinational, no handshake.
module string_window_cmp #(
    parameter int DWIDTH = 8,
    parameter int PATLEN = 16,
    parameter int PLW    = $clog2(PATLEN + 1)
) (
    input  logic [PATLEN*DWIDTH-1:0] win,
    input  logic [PATLEN*DWIDTH-1:0] pat,
    input  logic [PLW-1:0]           len,
    output logic                     hit
);

    always_comb begin
        hit = 1'b1;
        for (int i = 0; i < PATLEN; i++) begin
            if (PLW'(i) < len && win[i*DWIDTH +: DWIDTH] != pat[i*DWIDTH +: DWIDTH])
                hit = 1'b0;
        end
    end

endmodule

// File: rtl/string_match_scan.sv
// Buffers a string, then scans NPAT patterns, LANES start offsets per cycle; done pulses 1+sum(per-slot steps) cycles after str_last.
// str_ready high only in IDLE/LOAD_STR. Optional MATCH_POS_EN adds first-hit offsets.
module string_match_scan
    import string_match_pkg::*;
#(
    parameter int DWIDTH     = 8,
    parameter int MAX_STRLEN = 200,
    parameter int NPAT       = 16,
    parameter int PATLEN     = 16,
    parameter int LANES      = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pat_wr_en,
    input  logic [$clog2(NPAT)-1:0]        pat_wr_idx,
    input  logic [$clog2(PATLEN+1)-1:0]    pat_wr_len,
    input  logic [PATLEN*DWIDTH-1:0]       pat_wr_data,
    input  logic                           str_valid,
    input  logic [DWIDTH-1:0]              str_data,
    input  logic                           str_last,
    output logic                           str_ready,
    output logic                           busy,
    output logic [2*NPAT-1:0]              result,
    output logic                           done,
`ifdef MATCH_POS_EN
    output logic [NPAT*$clog2(MAX_STRLEN)-1:0] match_pos,
`endif
    output logic                           str_overflow
);

    localparam int LW   = cnt_width(MAX_STRLEN);
    localparam int CW0  = cnt_width(MAX_STRLEN + LANES + PATLEN);
    localparam int CW   = (CW0 > LW + 1) ? CW0 : LW + 1;
    localparam int IDXW = $clog2(MAX_STRLEN);
    localparam int PSW  = $clog2(MAX_STRLEN);
    localparam int PLW  = $clog2(PATLEN + 1);
    localparam int PW   = $clog2(NPAT);

    state_t                   state;
    logic [PW-1:0]            p;
    logic [LW-1:0]            s;
    logic [LW-1:0]            strlen;
    logic [DWIDTH-1:0]        buf_mem [MAX_STRLEN];
    logic [PLW-1:0]           pat_len [NPAT];
    logic [PATLEN*DWIDTH-1:0] pat_dat [NPAT];

    logic [PLW-1:0]           cur_len;
    logic [PATLEN*DWIDTH-1:0] cur_pat;
    logic [CW-1:0]            len_w, str_w, s_w, idx;
    logic [PATLEN*DWIDTH-1:0] win [LANES];
    logic [LANES-1:0]         win_vld, win_hit;
    logic                     hit_any;
    logic [LW-1:0]            hit_pos;
    logic                     step_adv, step_wr;
    logic [1:0]               step_res;
    logic                     buf_we;
    logic [IDXW-1:0]          buf_waddr;

    assign str_ready = (state == ST_IDLE || state == ST_LOAD_STR) && !reset;
    assign busy      = (state != ST_IDLE);
    assign buf_we    = str_valid && str_ready && (state == ST_IDLE || strlen < LW'(MAX_STRLEN));
    assign buf_waddr = (state == ST_IDLE) ? '0 : strlen[IDXW-1:0];

    always_ff @(posedge clk) begin
        if (buf_we)
            buf_mem[buf_waddr] <= str_data;
    end

    // Window fetch; offsets past the buffer read as zero and are masked by win_vld.
    always_comb begin
        cur_len = pat_len[p];
        cur_pat = pat_dat[p];
        len_w   = CW'(cur_len);
        str_w   = CW'(strlen);
        s_w     = CW'(s);
        idx     = '0;
        win_vld = '0;
        for (int k = 0; k < LANES; k++) begin
            win[k]     = '0;
            win_vld[k] = (s_w + CW'(k) + len_w) <= str_w;
            for (int i = 0; i < PATLEN; i++) begin
                idx = s_w + CW'(k + i);
                if (idx < CW'(MAX_STRLEN))
                    win[k][i*DWIDTH +: DWIDTH] = buf_mem[idx[IDXW-1:0]];
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        string_window_cmp #(.DWIDTH(DWIDTH), .PATLEN(PATLEN)) u_cmp (
            .win (win[k]),
            .pat (cur_pat),
            .len (cur_len),
            .hit (win_hit[k])
        );
    end

    always_comb begin
        hit_any = 1'b0;
        hit_pos = s;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (win_vld[k] && win_hit[k]) begin
                hit_any = 1'b1;
                hit_pos = s + LW'(k);
            end
        end
        step_adv = 1'b0;
        step_wr  = 1'b0;
        step_res = RES_NONE;
        if (cur_len == '0) begin
            step_adv = 1'b1;
        end else if (len_w > str_w) begin
            step_adv = 1'b1; step_wr = 1'b1; step_res = RES_MISS;
        end else if (hit_any) begin
            step_adv = 1'b1; step_wr = 1'b1; step_res = RES_HIT;
        end else if (s_w + CW'(LANES) > str_w - len_w) begin
            step_adv = 1'b1; step_wr = 1'b1; step_res = RES_MISS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            p            <= '0;
            s            <= '0;
            strlen       <= '0;
            done         <= 1'b0;
            str_overflow <= 1'b0;
            result       <= {NPAT{RES_NONE}};
`ifdef MATCH_POS_EN
            match_pos    <= '0;
`endif
            for (int n = 0; n < NPAT; n++)
                pat_len[n] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pat_wr_en) begin
                        pat_len[pat_wr_idx] <= pat_wr_len;
                        pat_dat[pat_wr_idx] <= pat_wr_data;
                    end
                    if (str_valid) begin
                        result       <= {NPAT{RES_NONE}};
                        str_overflow <= 1'b0;
`ifdef MATCH_POS_EN
                        match_pos    <= '0;
`endif
                        strlen       <= LW'(1);
                        p            <= '0;
                        s            <= '0;
                        state        <= str_last ? ST_SCAN : ST_LOAD_STR;
                    end
                end
                ST_LOAD_STR: begin
                    if (str_valid) begin
                        if (strlen < LW'(MAX_STRLEN))
                            strlen <= strlen + LW'(1);
                        else
                            str_overflow <= 1'b1;
                        if (str_last) begin
                            state <= ST_SCAN;
                            p     <= '0;
                            s     <= '0;
                        end
                    end
                end
                ST_SCAN: begin
                    if (step_wr)
                        result[2*int'(p) +: 2] <= step_res;
`ifdef MATCH_POS_EN
                    if (step_wr && step_res == RES_HIT)
                        match_pos[PSW*int'(p) +: PSW] <= PSW'(hit_pos);
`endif
                    if (step_adv) begin
                        s <= '0;
                        if (p == PW'(NPAT - 1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            p <= p + PW'(1);
                        end
                    end else begin
                        s <= s + LW'(LANES);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_string_match_scan.sv
// Randomised and directed checks of string_match_scan against a naive-search reference model.
module tb_string_match_scan;

    localparam int DW     = 8;
    localparam int MAXS   = 200;
    localparam int NPAT   = 16;
    localparam int PATLEN = 16;
    localparam int LANES  = 4;
    localparam int PSW    = $clog2(MAXS);
    localparam logic [2*NPAT-1:0] ALL_NONE = {NPAT{2'd2}};

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   pat_wr_en = 1'b0;
    logic [3:0]             pat_wr_idx = '0;
    logic [4:0]             pat_wr_len = '0;
    logic [PATLEN*DW-1:0]   pat_wr_data = '0;
    logic                   str_valid = 1'b0;
    logic [DW-1:0]          str_data = '0;
    logic                   str_last = 1'b0;
    logic                   str_ready, busy, done, str_overflow;
    logic [2*NPAT-1:0]      result;
`ifdef MATCH_POS_EN
    logic [NPAT*PSW-1:0]    match_pos;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]           str_q[$];
    int                   m_len [NPAT];
    logic [PATLEN*DW-1:0] m_pat [NPAT];
    int                   exp_res [NPAT];
    int                   exp_pos [NPAT];
    int                   exp_cyc;

    string_match_scan #(.DWIDTH(DW), .MAX_STRLEN(MAXS), .NPAT(NPAT), .PATLEN(PATLEN), .LANES(LANES)) dut (
        .clk          (clk),
        .reset        (reset),
        .pat_wr_en    (pat_wr_en),
        .pat_wr_idx   (pat_wr_idx),
        .pat_wr_len   (pat_wr_len),
        .pat_wr_data  (pat_wr_data),
        .str_valid    (str_valid),
        .str_data     (str_data),
        .str_last     (str_last),
        .str_ready    (str_ready),
        .busy         (busy),
        .result       (result),
        .done         (done),
`ifdef MATCH_POS_EN
        .match_pos    (match_pos),
`endif
        .str_overflow (str_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int get_res(input int p);
        return int'(result[2*p +: 2]);
    endfunction

`ifdef MATCH_POS_EN
    function automatic int get_pos(input int p);
        return int'(match_pos[PSW*p +: PSW]);
    endfunction
`endif

    function automatic logic [PATLEN*DW-1:0] pack_str(input string t);
        logic [PATLEN*DW-1:0] d = '0;
        for (int i = 0; i < t.len(); i++)
            d[i*8 +: 8] = t[i];
        return d;
    endfunction

    task automatic load_str(input string t);
        str_q.delete();
        for (int i = 0; i < t.len(); i++)
            str_q.push_back(t[i]);
    endtask

    // Reference: naive first-occurrence search; cycle cost from the step-count rule.
    task automatic compute_model();
        int sl;
        sl = (str_q.size() > MAXS) ? MAXS : str_q.size();
        exp_cyc = 1;
        for (int p = 0; p < NPAT; p++) begin
            int L;
            int found;
            L = m_len[p];
            found = -1;
            exp_res[p] = 2;
            exp_pos[p] = 0;
            if (L == 0) begin
                exp_cyc += 1;
            end else begin
                for (int o = 0; o + L <= sl && found < 0; o++) begin
                    bit ok;
                    ok = 1'b1;
                    for (int i = 0; i < L; i++)
                        if (str_q[o+i] !== m_pat[p][i*8 +: 8]) ok = 1'b0;
                    if (ok) found = o;
                end
                if (found >= 0) begin
                    exp_res[p] = 1;
                    exp_pos[p] = found;
                    exp_cyc += found / LANES + 1;
                end else begin
                    exp_res[p] = 0;
                    exp_cyc += (sl - L + 1 <= 0) ? 1 : (sl - L + 1 + LANES - 1) / LANES;
                end
            end
        end
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 50 && busy !== 1'b0; w++)
            @(negedge clk);
    endtask

    task automatic write_pat(input int idx, input int len, input logic [PATLEN*DW-1:0] d);
        wait_idle();
        pat_wr_en   = 1'b1;
        pat_wr_idx  = 4'(idx);
        pat_wr_len  = 5'(len);
        pat_wr_data = d;
        @(posedge clk); #1;
        pat_wr_en = 1'b0;
        m_len[idx] = len;
        m_pat[idx] = d;
    endtask

    task automatic setup_patterns();
        for (int p = 0; p < NPAT; p++)
            write_pat(p, 0, '0);
        write_pat(0, 3, pack_str("LOW"));
        write_pat(1, 3, pack_str("XYZ"));
        write_pat(2, 5, pack_str("WORLD"));
    endtask

    // Returns one time unit after the edge that accepted the last beat.
    task automatic send_string();
        @(negedge clk);
        for (int w = 0; w < 50 && str_ready !== 1'b1; w++)
            @(negedge clk);
        for (int i = 0; i < str_q.size(); i++) begin
            str_valid = 1'b1;
            str_data  = str_q[i];
            str_last  = (i == str_q.size() - 1);
            @(posedge clk); #1;
        end
        str_valid = 1'b0;
        str_last  = 1'b0;
    endtask

    // n = clock edges from here until done is seen; -1 if it never comes.
    task automatic wait_done(output int n);
        n = -1;
        for (int e = 1; e <= 2000; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                n = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (str_ready !== 1'b0) begin miscompares++; $display("FAIL reset_str_ready: got %b want 0", str_ready); end
        vectors++; if (result !== ALL_NONE) begin miscompares++; $display("FAIL reset_result: got %h want %h", result, ALL_NONE); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (str_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf: got %b want 0", str_overflow); end
`ifdef MATCH_POS_EN
        vectors++; if (match_pos !== '0) begin miscompares++; $display("FAIL reset_match_pos: got %h want 0", match_pos); end
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (str_ready !== 1'b1) begin miscompares++; $display("FAIL idle_str_ready: got %b want 1", str_ready); end
    endtask

    task automatic test_basic_match();
        int n;
        setup_patterns();
        load_str("HELLOWORLD");
        send_string();
        wait_done(n);
        vectors++; if (n + 1 != 19) begin miscompares++; $display("FAIL basic_latency: got %0d want 19", n + 1); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_at_done: got %b want 1", busy); end
        vectors++; if (get_res(0) != 1) begin miscompares++; $display("FAIL basic_slot0: got %0d want 1", get_res(0)); end
        vectors++; if (get_res(1) != 0) begin miscompares++; $display("FAIL basic_slot1: got %0d want 0", get_res(1)); end
        vectors++; if (get_res(2) != 1) begin miscompares++; $display("FAIL basic_slot2: got %0d want 1", get_res(2)); end
        for (int p = 3; p < NPAT; p++) begin
            vectors++; if (get_res(p) != 2) begin miscompares++; $display("FAIL basic_slot%0d: got %0d want 2", p, get_res(p)); end
        end
`ifdef MATCH_POS_EN
        vectors++; if (get_pos(0) != 3) begin miscompares++; $display("FAIL basic_pos0: got %0d want 3", get_pos(0)); end
        vectors++; if (get_pos(2) != 5) begin miscompares++; $display("FAIL basic_pos2: got %0d want 5", get_pos(2)); end
        vectors++; if (get_pos(1) != 0) begin miscompares++; $display("FAIL basic_pos1: got %0d want 0", get_pos(1)); end
`endif
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_width: got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        vectors++; if (get_res(2) != 1) begin miscompares++; $display("FAIL basic_hold_slot2: got %0d want 1", get_res(2)); end
    endtask

    task automatic test_short_string();
        int n;
        load_str("LO");
        send_string();
        wait_done(n);
        vectors++; if (n + 1 != 17) begin miscompares++; $display("FAIL short_latency: got %0d want 17", n + 1); end
        for (int p = 0; p < 3; p++) begin
            vectors++; if (get_res(p) != 0) begin miscompares++; $display("FAIL short_slot%0d: got %0d want 0", p, get_res(p)); end
        end
        vectors++; if (get_res(3) != 2) begin miscompares++; $display("FAIL short_slot3: got %0d want 2", get_res(3)); end
    endtask

    task automatic test_overflow();
        int n;
        write_pat(3, 2, pack_str("AB"));
        write_pat(4, 2, pack_str("QQ"));
        str_q.delete();
        for (int i = 0; i < 205; i++)
            str_q.push_back(8'($urandom_range(97, 122)));
        str_q[198] = 8'h41;
        str_q[199] = 8'h42;
        str_q[202] = 8'h51;
        str_q[203] = 8'h51;
        compute_model();
        send_string();
        wait_done(n);
        vectors++; if (str_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", str_overflow); end
        vectors++; if (n + 1 != exp_cyc) begin miscompares++; $display("FAIL ovf_latency: got %0d want %0d", n + 1, exp_cyc); end
        vectors++; if (get_res(3) != 1) begin miscompares++; $display("FAIL ovf_tail_hit: got %0d want 1", get_res(3)); end
        vectors++; if (get_res(4) != 0) begin miscompares++; $display("FAIL ovf_dropped_bytes: got %0d want 0", get_res(4)); end
        for (int p = 0; p < NPAT; p++) begin
            vectors++; if (get_res(p) != exp_res[p]) begin miscompares++; $display("FAIL ovf_slot%0d: got %0d want %0d", p, get_res(p), exp_res[p]); end
        end
`ifdef MATCH_POS_EN
        vectors++; if (get_pos(3) != 198) begin miscompares++; $display("FAIL ovf_pos3: got %0d want 198", get_pos(3)); end
`endif
    endtask

    task automatic test_reset_mid_scan();
        int n;
        int seen;
        setup_patterns();
        load_str("HELLOWORLD");
        send_string();
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (result !== ALL_NONE) begin miscompares++; $display("FAIL rst_scan_result: got %h want %h", result, ALL_NONE); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_scan_done: got %b want 0", done); end
        vectors++; if (str_ready !== 1'b1) begin miscompares++; $display("FAIL rst_scan_ready: got %b want 1", str_ready); end
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        vectors++; if (seen != 0) begin miscompares++; $display("FAIL rst_scan_no_done: got %0d pulses want 0", seen); end
        for (int p = 0; p < NPAT; p++)
            m_len[p] = 0;
        compute_model();
        send_string();
        wait_done(n);
        vectors++; if (n + 1 != exp_cyc) begin miscompares++; $display("FAIL rst_cleared_latency: got %0d want %0d", n + 1, exp_cyc); end
        vectors++; if (result !== ALL_NONE) begin miscompares++; $display("FAIL rst_cleared_table: got %h want %h", result, ALL_NONE); end
    endtask

    task automatic test_wr_during_scan();
        int n;
        setup_patterns();
        load_str("HELLOWORLD");
        send_string();
        pat_wr_en   = 1'b1;
        pat_wr_idx  = 4'd1;
        pat_wr_len  = 5'd3;
        pat_wr_data = pack_str("ELL");
        @(posedge clk); #1;
        pat_wr_en = 1'b0;
        wait_done(n);
        vectors++; if (n < 0 || n + 2 != 19) begin miscompares++; $display("FAIL wr_scan_latency: got %0d want 19", n + 2); end
        vectors++; if (get_res(0) != 1) begin miscompares++; $display("FAIL wr_scan_slot0: got %0d want 1", get_res(0)); end
        vectors++; if (get_res(1) != 0) begin miscompares++; $display("FAIL wr_scan_slot1: got %0d want 0", get_res(1)); end
        vectors++; if (get_res(2) != 1) begin miscompares++; $display("FAIL wr_scan_slot2: got %0d want 1", get_res(2)); end
        load_str("HELLO");
        compute_model();
        send_string();
        wait_done(n);
        for (int p = 0; p < 4; p++) begin
            vectors++; if (get_res(p) != exp_res[p]) begin miscompares++; $display("FAIL wr_scan_after_slot%0d: got %0d want %0d", p, get_res(p), exp_res[p]); end
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 8; it++) begin
            for (int p = 0; p < NPAT; p++) begin
                int len;
                logic [PATLEN*DW-1:0] d;
                len = $urandom_range(0, 5);
                d = '0;
                for (int i = 0; i < len; i++)
                    d[i*8 +: 8] = 8'($urandom_range(97, 100));
                write_pat(p, len, d);
            end
            str_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++)
                str_q.push_back(8'($urandom_range(97, 100)));
            compute_model();
            send_string();
            wait_done(n);
            vectors++; if (n + 1 != exp_cyc) begin miscompares++; $display("FAIL rand%0d_latency: got %0d want %0d", it, n + 1, exp_cyc); end
            vectors++; if (str_overflow !== 1'b0) begin miscompares++; $display("FAIL rand%0d_ovf: got %b want 0", it, str_overflow); end
            for (int p = 0; p < NPAT; p++) begin
                vectors++; if (get_res(p) != exp_res[p]) begin miscompares++; $display("FAIL rand%0d_slot%0d: got %0d want %0d", it, p, get_res(p), exp_res[p]); end
`ifdef MATCH_POS_EN
                vectors++; if (get_pos(p) != exp_pos[p]) begin miscompares++; $display("FAIL rand%0d_pos%0d: got %0d want %0d", it, p, get_pos(p), exp_pos[p]); end
`endif
            end
        end
    endtask

    initial begin
        for (int p = 0; p < NPAT; p++) begin
            m_len[p] = 0;
            m_pat[p] = '0;
        end
        test_reset();
        test_basic_match();
        test_short_string();
        test_overflow();
        test_reset_mid_scan();
        test_wr_during_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
